// File: rtl/hazard_ctrl_pkg.sv
// Shared stall-vector encodings and FSM state type for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam logic [2:0] STALL_PC_IFID         = 3'b001;
  localparam logic [2:0] STALL_IDEX            = 3'b010;
  localparam logic [2:0] STALL_EXMEM           = 3'b100;
  localparam logic [2:0] STALL_MASK_IDEX_EXMEM = 3'b110;
  localparam logic [2:0] STALL_ALL             = STALL_PC_IFID | STALL_MASK_IDEX_EXMEM;

  typedef enum logic [1:0] {
    ST_RUN           = 2'd0,
    ST_BUBBLE        = 2'd1,
    ST_MEM_WAIT      = 2'd2,
    ST_REDIRECT_PEND = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: an EX load whose destination feeds a live ID source.
module load_use_detect (
  input  logic [4:0] id_r1_addr_i,
  input  logic [4:0] id_r2_addr_i,
  input  logic       id_r1_used_i,
  input  logic       id_r2_used_i,
  input  logic       ex_is_load_i,
  input  logic [4:0] ex_rd_addr_i,
  output logic       hazard_o
);

  logic r1_match;
  logic r2_match;

  assign r1_match = id_r1_used_i && (id_r1_addr_i == ex_rd_addr_i);
  assign r2_match = id_r2_used_i && (id_r2_addr_i == ex_rd_addr_i);

  // x0 is hardwired to zero, so writing it never creates a dependency
  assign hazard_o = ex_is_load_i && (ex_rd_addr_i != 5'd0) && (r1_match || r2_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: load-use bubbles, memory back-pressure, branch redirects
// (deferred while memory is busy) and a profiling counter of stalled cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             if_busy,
  input  logic             mem_busy,
  input  logic [4:0]       id_r1_addr,
  input  logic [4:0]       id_r2_addr,
  input  logic             id_r1_used,
  input  logic             id_r2_used,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  output logic [2:0]       stall,
  output logic             clear_ifid,
  output logic             clear_idex,
  output logic             pc_redirect,
  output logic [31:0]      pc_redirect_target,
  output logic [CNT_W-1:0] stall_cycles
);

  hz_state_e        state_q, state_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;

  logic [2:0]  stall_c;
  logic        clr_ifid_c;
  logic        clr_idex_c;
  logic        redir_c;
  logic [31:0] redir_tgt_c;

  load_use_detect u_lud (
    .id_r1_addr_i (id_r1_addr),
    .id_r2_addr_i (id_r2_addr),
    .id_r1_used_i (id_r1_used),
    .id_r2_used_i (id_r2_used),
    .ex_is_load_i (ex_is_load),
    .ex_rd_addr_i (ex_rd_addr),
    .hazard_o     (hazard)
  );

  always_comb begin
    stall_c     = 3'b000;
    clr_ifid_c  = 1'b0;
    clr_idex_c  = 1'b0;
    redir_c     = 1'b0;
    redir_tgt_c = 32'h0;
    state_d     = state_q;
    tgt_d       = tgt_q;

    if (!rst_n_in) begin
      state_d = ST_RUN;
    end else if (!rdy_in) begin
      stall_c = STALL_ALL;
    end else if (mem_busy) begin
      stall_c = STALL_ALL;
      if ((state_q == ST_RUN || state_q == ST_MEM_WAIT) && ex_branch_taken) begin
        tgt_d   = ex_branch_target;
        state_d = ST_REDIRECT_PEND;
      end else if (state_q != ST_REDIRECT_PEND) begin
        state_d = ST_MEM_WAIT;
      end
    end else if (state_q == ST_REDIRECT_PEND) begin
      // The branch still visible in EX is the one already latched; do not issue it twice
      redir_c     = 1'b1;
      redir_tgt_c = tgt_q;
      clr_ifid_c  = 1'b1;
      clr_idex_c  = 1'b1;
      state_d     = ST_RUN;
    end else if (ex_branch_taken) begin
      redir_c     = 1'b1;
      redir_tgt_c = ex_branch_target;
      clr_ifid_c  = 1'b1;
      clr_idex_c  = 1'b1;
      state_d     = ST_RUN;
    end else if (hazard && state_q != ST_BUBBLE) begin
      stall_c    = STALL_PC_IFID;
      clr_idex_c = 1'b1;
      state_d    = ST_BUBBLE;
    end else if (if_busy) begin
      stall_c    = STALL_PC_IFID;
      clr_idex_c = 1'b1;
      state_d    = ST_RUN;
    end else begin
      state_d = ST_RUN;
    end
  end

  assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, (rdy_in && (stall_c != 3'b000))};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_RUN;
      tgt_q   <= 32'h0;
      cnt_q   <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall              = stall_c;
  assign clear_ifid         = clr_ifid_c;
  assign clear_idex         = clr_idex_c;
  assign pc_redirect        = redir_c;
  assign pc_redirect_target = redir_tgt_c;
  assign stall_cycles       = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, multi-cycle corner sequences, random vs model.
module tb_hazard_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in, if_busy, mem_busy;
  logic [4:0]  id_r1_addr, id_r2_addr, ex_rd_addr;
  logic        id_r1_used, id_r2_used, ex_is_load, ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic [2:0]  stall;
  logic        clear_ifid, clear_idex, pc_redirect;
  logic [31:0] pc_redirect_target;
  logic [31:0] stall_cycles;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_in = ~clk_in;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .if_busy(if_busy),
    .mem_busy(mem_busy), .id_r1_addr(id_r1_addr), .id_r2_addr(id_r2_addr),
    .id_r1_used(id_r1_used), .id_r2_used(id_r2_used), .ex_is_load(ex_is_load),
    .ex_rd_addr(ex_rd_addr), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .stall(stall), .clear_ifid(clear_ifid),
    .clear_idex(clear_idex), .pc_redirect(pc_redirect),
    .pc_redirect_target(pc_redirect_target), .stall_cycles(stall_cycles)
  );

  // Reference model: a pending-redirect flag, a "bubble just issued" flag and a counter
  logic        m_pend, m_bub;
  logic [31:0] m_tgt, m_cnt;

  typedef struct packed {
    logic [2:0]  stall;
    logic        cif, cid, red;
    logic [31:0] tgt;
  } out_t;

  function automatic logic m_hazard();
    return ex_is_load && ex_rd_addr != 0 &&
           ((id_r1_used && id_r1_addr == ex_rd_addr) || (id_r2_used && id_r2_addr == ex_rd_addr));
  endfunction

  function automatic out_t m_out();
    out_t o = '0;
    if (!rst_n_in) return o;
    if (!rdy_in || mem_busy) o.stall = 3'b111;
    else if (m_pend) begin o.red = 1; o.tgt = m_tgt; o.cif = 1; o.cid = 1; end
    else if (ex_branch_taken) begin o.red = 1; o.tgt = ex_branch_target; o.cif = 1; o.cid = 1; end
    else if ((!m_bub && m_hazard()) || if_busy) begin o.stall = 3'b001; o.cid = 1; end
    return o;
  endfunction

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_pend <= 0; m_bub <= 0; m_tgt <= 0; m_cnt <= 0;
    end else if (rdy_in) begin
      if (m_out().stall != 0) m_cnt <= m_cnt + 1;
      if (mem_busy) begin
        if (!m_pend && !m_bub && ex_branch_taken) begin
          m_pend <= 1; m_tgt <= ex_branch_target;
        end
        m_bub <= 0;
      end else if (m_pend || ex_branch_taken) begin
        m_pend <= 0; m_bub <= 0;
      end else begin
        m_bub <= !m_bub && m_hazard();
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input out_t e);
    chk({nm, ".stall"}, 64'(stall), 64'(e.stall));
    chk({nm, ".clear_ifid"}, 64'(clear_ifid), 64'(e.cif));
    chk({nm, ".clear_idex"}, 64'(clear_idex), 64'(e.cid));
    chk({nm, ".pc_redirect"}, 64'(pc_redirect), 64'(e.red));
    chk({nm, ".target"}, 64'(pc_redirect_target), 64'(e.tgt));
  endtask

  typedef struct {
    logic        rdy, ifb, memb, ld;
    logic [4:0]  rd, r1, r2;
    logic        u1, u2, br;
    logic [31:0] btgt;
    out_t        e;
  } vec_t;

  function automatic vec_t mk(logic rdy, logic ifb, logic memb, logic ld, logic [4:0] rd,
                              logic [4:0] r1, logic u1, logic [4:0] r2, logic u2,
                              logic br, logic [31:0] btgt,
                              logic [2:0] es, logic ecif, logic ecid, logic ered, logic [31:0] etgt);
    vec_t v;
    v.rdy = rdy; v.ifb = ifb; v.memb = memb; v.ld = ld; v.rd = rd;
    v.r1 = r1; v.u1 = u1; v.r2 = r2; v.u2 = u2; v.br = br; v.btgt = btgt;
    v.e.stall = es; v.e.cif = ecif; v.e.cid = ecid; v.e.red = ered; v.e.tgt = etgt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rdy_in = v.rdy; if_busy = v.ifb; mem_busy = v.memb; ex_is_load = v.ld;
    ex_rd_addr = v.rd; id_r1_addr = v.r1; id_r1_used = v.u1; id_r2_addr = v.r2;
    id_r2_used = v.u2; ex_branch_taken = v.br; ex_branch_target = v.btgt;
  endtask

  // One cycle: at the falling edge check the counter, drive inputs, then check outputs
  task automatic apply(input string nm, input vec_t v);
    @(negedge clk_in);
    chk({nm, ".stall_cycles"}, 64'(stall_cycles), 64'(m_cnt));
    drive(v);
    #2;
    chk_out(nm, v.e);
  endtask

  vec_t tbl[13];
  vec_t idle;
  logic [31:0] cnt0;

  initial begin
    idle = mk(1,0,0,0,0, 0,0,0,0, 0,0, 3'b000,0,0,0,0);
    rst_n_in = 0;
    drive(mk(1,1,1,1,5, 5,1,0,0, 1,32'h44, 0,0,0,0,0));
    #12;
    chk_out("reset", '0);
    chk("reset.stall_cycles", 64'(stall_cycles), 64'd0);
    @(negedge clk_in);
    drive(idle);
    rst_n_in = 1;

    //           rdy ifb mb ld rd r1 u1 r2 u2 br tgt       stall cif cid red etgt
    tbl[0]  = mk(1,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0,        3'b000,0,0,0,0);
    tbl[1]  = mk(1,  0,  0, 1, 5, 5, 1, 0, 0, 0, 0,        3'b001,0,1,0,0);
    tbl[2]  = mk(1,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0,        3'b000,0,0,0,0);
    tbl[3]  = mk(1,  0,  0, 1, 0, 0, 1, 0, 1, 0, 0,        3'b000,0,0,0,0);
    tbl[4]  = mk(1,  0,  0, 1, 5, 5, 1, 0, 0, 1, 32'h100,  3'b000,1,1,1,32'h100);
    tbl[5]  = mk(1,  1,  0, 0, 0, 0, 0, 0, 0, 0, 0,        3'b001,0,1,0,0);
    tbl[6]  = mk(1,  0,  0, 1, 7, 3, 1, 7, 1, 0, 0,        3'b001,0,1,0,0);
    tbl[7]  = mk(1,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0,        3'b000,0,0,0,0);
    tbl[8]  = mk(1,  0,  0, 1, 7, 7, 0, 7, 0, 0, 0,        3'b000,0,0,0,0);
    tbl[9]  = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 32'h80,   3'b111,0,0,0,0);
    tbl[10] = mk(1,  0,  1, 0, 0, 0, 0, 0, 0, 0, 0,        3'b111,0,0,0,0);
    tbl[11] = mk(1,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0,        3'b000,0,0,0,0);
    tbl[12] = mk(0,  0,  0, 1, 5, 5, 1, 0, 0, 0, 0,        3'b111,0,0,0,0);
    for (int i = 0; i < 13; i++) apply($sformatf("tbl%0d", i), tbl[i]);
    apply("tbl_end", idle);

    // Branch during memory busy: three stalled cycles then one redirect to the latched target
    apply("mw_settle", idle);
    cnt0 = stall_cycles;
    apply("mw1", mk(1,0,1,0,0, 0,0,0,0, 1,32'h200, 3'b111,0,0,0,0));
    apply("mw2", mk(1,0,1,0,0, 0,0,0,0, 1,32'h200, 3'b111,0,0,0,0));
    apply("mw3", mk(1,0,1,0,0, 0,0,0,0, 1,32'h300, 3'b111,0,0,0,0));
    apply("mw4", mk(1,0,0,0,0, 0,0,0,0, 1,32'h300, 3'b000,1,1,1,32'h200));
    chk("mw.stall_delta", 64'(stall_cycles - cnt0), 64'd3);
    apply("mw5", idle);

    // rdy_in low while a redirect is pending: frozen, then the redirect issues once
    apply("rp_latch", mk(1,0,1,0,0, 0,0,0,0, 1,32'h400, 3'b111,0,0,0,0));
    apply("rp_frz1", mk(0,0,0,0,0, 0,0,0,0, 0,0, 3'b111,0,0,0,0));
    cnt0 = stall_cycles;
    apply("rp_frz2", mk(0,0,0,0,0, 0,0,0,0, 0,0, 3'b111,0,0,0,0));
    apply("rp_go", mk(1,0,0,0,0, 0,0,0,0, 0,0, 3'b000,1,1,1,32'h400));
    chk("rp.frozen_cnt", 64'(stall_cycles), 64'(cnt0));
    apply("rp_once", idle);

    // Asynchronous reset while a redirect is pending drops it
    apply("rs_latch", mk(1,0,1,0,0, 0,0,0,0, 1,32'h500, 3'b111,0,0,0,0));
    apply("rs_hold", mk(1,0,1,0,0, 0,0,0,0, 0,0, 3'b111,0,0,0,0));
    #1 rst_n_in = 0;
    #1 chk_out("rs_async", '0);
    chk("rs_async.stall_cycles", 64'(stall_cycles), 64'd0);
    @(negedge clk_in);
    drive(idle);
    rst_n_in = 1;
    apply("rs_after1", idle);
    apply("rs_after2", idle);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      @(negedge clk_in);
      chk("rnd.stall_cycles", 64'(stall_cycles), 64'(m_cnt));
      rdy_in           = ($urandom_range(0, 99) < 88);
      if_busy          = ($urandom_range(0, 99) < 20);
      mem_busy         = ($urandom_range(0, 99) < 25);
      ex_is_load       = ($urandom_range(0, 99) < 50);
      ex_rd_addr       = 5'($urandom_range(0, 3));
      id_r1_addr       = 5'($urandom_range(0, 3));
      id_r2_addr       = 5'($urandom_range(0, 3));
      id_r1_used       = 1'($urandom);
      id_r2_used       = 1'($urandom);
      ex_branch_taken  = ($urandom_range(0, 99) < 20);
      ex_branch_target = $urandom;
      #2;
      chk_out("rnd", m_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
